decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter RV32E, default 0; 1 = 16-register RV32E decode, 0 = 32-register RV32I.
REQ-002 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer, full throughput, registered in_ready; 0 = single output register, combinational in_ready.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  upstream instruction valid.
REQ-007 in_ready  out  1  stage can accept.
REQ-008 in_instr  in  32  instruction word (rv32i_inst_u).
REQ-009 in_pc  in  32  instruction address.
REQ-010 flush  in  1  discard all held and incoming instructions.
REQ-011 out_valid  out  1  decoded bundle valid.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 out_pc  out  32  pc of the bundle.
REQ-014 rs1, rs2, rd  out  5 each  register indices.
REQ-015 imm  out  32  sign-extended immediate.
REQ-016 r_we  out  1  destination register write enable.
REQ-017 rv_op  out  rv_op_e  operation.
REQ-018 illegal  out  1  instruction not decodable.

Function
REQ-019 SHALL transfer in on in_valid&in_ready and out on out_valid&out_ready, both sampled at rising clk.
REQ-020 SHALL decode combinationally from in_instr and register the result; an instruction transferred at edge N SHALL appear on outputs after edge N when the stage was empty (latency 1).
REQ-021 SHALL map opcodes: 0110111 LUI(U), 0010111 AUIPC(U), 1101111 JAL(J), 1100111 JALR(I, funct3=0), 1100011 branch(B), 0000011 load(I), 0100011 store(S), 0010011 op-imm(I), 0110011 op(R), 0001111 FENCE, 1110011 ECALL/EBREAK (funct3=0, imm 0/1, rs1=rd=0).
REQ-022 SHALL select rv_op from opcode, funct3 and funct7 (funct7 bit 5 selects SUB/SRA/SRAI), covering all 40 RV32I base instructions.
REQ-023 SHALL form imm per type: I {20{i[31]},i[31:20]}; S {20{i[31]},i[31:25],i[11:7]}; B {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}; R, FENCE and SYSTEM 0.
REQ-024 SHALL drive unused rs1/rs2/rd fields as 0 (U/J: rs1=rs2=0; I: rs2=0; S/B: rd=0).
REQ-025 SHALL set r_we=1 only for U, J, I (JALR/load/op-imm) and R types with rd!=0; else 0.
REQ-026 SHALL set illegal=1 for: i[1:0]!=2'b11, unknown opcode, unlisted funct3/funct7 combination, or with RV32E=1 any used register index >=16.
REQ-027 When illegal=1, SHALL force r_we=0, rs1=rs2=rd=0, imm=0, rv_op=ADDI; out_pc SHALL still be the instruction pc.
REQ-028 SKID=1: SHALL hold a main entry and a skid entry; in_ready SHALL be the registered value of "skid entry empty"; when out stalls, the next accepted instruction SHALL land in the skid entry; order SHALL be preserved.
REQ-029 SKID=0: in_ready SHALL equal !out_valid | out_ready.
REQ-030 Simultaneous in and out transfers SHALL sustain one instruction per cycle with no bubble.
REQ-031 flush SHALL empty all entries at that edge; an input transfer in the same cycle SHALL be discarded; the next cycle SHALL have out_valid=0 and in_ready=1.
REQ-032 Outputs other than valid/ready SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-033 While rst=1: out_valid=0, in_ready=0, and all entries empty.
REQ-034 After the rst release edge: in_ready=1, and out_pc, rs1, rs2, rd, imm, r_we, illegal all 0, rv_op=ADDI.
REQ-035 rst mid-operation SHALL discard all held instructions, with flush priority irrelevant.

Verification
REQ-036 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, rv_op=ADDI, r_we=1, out_pc=0x100.
REQ-037 0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, imm=0xFFFFFFFC, rv_op=BEQ, r_we=0, illegal=0.
REQ-038 SKID=1, out_ready=0, three back-to-back instructions -> first held on out, second in skid, in_ready=0, third held upstream; out_ready=1 -> all three emitted in order, one per cycle.
REQ-039 0xFFFFFFFF -> illegal=1, r_we=0, rv_op=ADDI; 0x01000833 (add x16,x0,x16) -> illegal=1 with RV32E=1, and illegal=0, rd=16, r_we=1 with RV32E=0.
REQ-040 Both entries full plus flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, with no flushed instruction ever emitted.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV32E instruction decode stage: combinational decode of the incoming word,
// registered into a main entry with an optional skid entry behind valid/ready handshakes.
package decode_stage_pkg;

  typedef enum logic [5:0] {
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_ECALL, OP_EBREAK
  } rv_op_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rv32i_fields_t;

  typedef union packed {
    logic [31:0]   raw;
    rv32i_fields_t f;
  } rv32i_inst_u;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        r_we;
    rv_op_e      op;
    logic        illegal;
  } bundle_t;

endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit RV32E = 1'b0,
  parameter bit SKID  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  rv32i_inst_u in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        r_we,
  output rv_op_e      rv_op,
  output logic        illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits for ready, and a held bundle stays unchanged until it transfers.

  localparam bundle_t RST_BUNDLE = '{pc: 32'h0, rs1: 5'h0, rs2: 5'h0, rd: 5'h0, imm: 32'h0,
                                     r_we: 1'b0, op: OP_ADDI, illegal: 1'b0};

  logic [31:0] ir;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ir    = in_instr.raw;
  assign opc   = in_instr.f.opcode;
  assign f3    = in_instr.f.funct3;
  assign f7    = in_instr.f.funct7;
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  rv_op_e      d_op;
  logic [31:0] d_imm;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_wr;
  logic        d_ill;
  bundle_t     dec;

  always_comb begin
    d_op  = OP_ADDI;
    d_imm = 32'h0;
    d_rs1 = 5'h0;
    d_rs2 = 5'h0;
    d_rd  = 5'h0;
    d_wr  = 1'b0;
    d_ill = 1'b0;
    unique case (opc)
      7'b0110111: begin d_op = OP_LUI;   d_imm = imm_u; d_rd = in_instr.f.rd; d_wr = 1'b1; end
      7'b0010111: begin d_op = OP_AUIPC; d_imm = imm_u; d_rd = in_instr.f.rd; d_wr = 1'b1; end
      7'b1101111: begin d_op = OP_JAL;   d_imm = imm_j; d_rd = in_instr.f.rd; d_wr = 1'b1; end
      7'b1100111: begin
        d_op = OP_JALR; d_imm = imm_i; d_rs1 = in_instr.f.rs1; d_rd = in_instr.f.rd; d_wr = 1'b1;
        if (f3 != 3'b000) d_ill = 1'b1;
      end
      7'b1100011: begin
        d_imm = imm_b; d_rs1 = in_instr.f.rs1; d_rs2 = in_instr.f.rs2;
        case (f3)
          3'b000:  d_op = OP_BEQ;
          3'b001:  d_op = OP_BNE;
          3'b100:  d_op = OP_BLT;
          3'b101:  d_op = OP_BGE;
          3'b110:  d_op = OP_BLTU;
          3'b111:  d_op = OP_BGEU;
          default: d_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        d_imm = imm_i; d_rs1 = in_instr.f.rs1; d_rd = in_instr.f.rd; d_wr = 1'b1;
        case (f3)
          3'b000:  d_op = OP_LB;
          3'b001:  d_op = OP_LH;
          3'b010:  d_op = OP_LW;
          3'b100:  d_op = OP_LBU;
          3'b101:  d_op = OP_LHU;
          default: d_ill = 1'b1;
        endcase
      end
      7'b0100011: begin
        d_imm = imm_s; d_rs1 = in_instr.f.rs1; d_rs2 = in_instr.f.rs2;
        case (f3)
          3'b000:  d_op = OP_SB;
          3'b001:  d_op = OP_SH;
          3'b010:  d_op = OP_SW;
          default: d_ill = 1'b1;
        endcase
      end
      7'b0010011: begin
        // Shift-immediates keep the raw I-format immediate, so SRAI carries bit 10 set.
        d_imm = imm_i; d_rs1 = in_instr.f.rs1; d_rd = in_instr.f.rd; d_wr = 1'b1;
        case (f3)
          3'b000: d_op = OP_ADDI;
          3'b010: d_op = OP_SLTI;
          3'b011: d_op = OP_SLTIU;
          3'b100: d_op = OP_XORI;
          3'b110: d_op = OP_ORI;
          3'b111: d_op = OP_ANDI;
          3'b001: begin
            d_op = OP_SLLI;
            if (f7 != 7'b0000000) d_ill = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      d_op = OP_SRLI;
            else if (f7 == 7'b0100000) d_op = OP_SRAI;
            else                       d_ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        d_rs1 = in_instr.f.rs1; d_rs2 = in_instr.f.rs2; d_rd = in_instr.f.rd; d_wr = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d_op = OP_ADD;
            3'b001:  d_op = OP_SLL;
            3'b010:  d_op = OP_SLT;
            3'b011:  d_op = OP_SLTU;
            3'b100:  d_op = OP_XOR;
            3'b101:  d_op = OP_SRL;
            3'b110:  d_op = OP_OR;
            default: d_op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d_op = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d_op = OP_SRA;
        end else begin
          d_ill = 1'b1;
        end
      end
      7'b0001111: begin
        d_op = OP_FENCE;
        if (f3 != 3'b000) d_ill = 1'b1;
      end
      7'b1110011: begin
        if (f3 == 3'b000 && in_instr.f.rs1 == 5'h0 && in_instr.f.rd == 5'h0 &&
            ir[31:20] == 12'h000)
          d_op = OP_ECALL;
        else if (f3 == 3'b000 && in_instr.f.rs1 == 5'h0 && in_instr.f.rd == 5'h0 &&
                 ir[31:20] == 12'h001)
          d_op = OP_EBREAK;
        else
          d_ill = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (ir[1:0] != 2'b11) d_ill = 1'b1;
    // Unused index fields are already zero, so only real operands can trip this.
    if (RV32E && (d_rs1[4] || d_rs2[4] || d_rd[4])) d_ill = 1'b1;
  end

  always_comb begin
    dec    = RST_BUNDLE;
    dec.pc = in_pc;
    if (d_ill) begin
      dec.illegal = 1'b1;
    end else begin
      dec.rs1  = d_rs1;
      dec.rs2  = d_rs2;
      dec.rd   = d_rd;
      dec.imm  = d_imm;
      dec.op   = d_op;
      dec.r_we = d_wr && (d_rd != 5'h0);
    end
  end

  logic    m_valid_q, m_valid_d;
  logic    s_valid_q, s_valid_d;
  logic    rdy_q;
  bundle_t m_q, m_d;
  bundle_t s_q, s_d;
  logic    in_fire, out_fire;

  assign in_ready = !rst && (SKID ? rdy_q : (!m_valid_q || out_ready));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (out_fire || !m_valid_q) begin
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = in_fire;
        if (in_fire) s_d = dec;
      end else begin
        m_valid_d = in_fire;
        if (in_fire) m_d = dec;
      end
    end else if (in_fire) begin
      // Main entry is stalled: park the newcomer behind it.
      s_valid_d = 1'b1;
      s_d       = dec;
    end
    if (!SKID) s_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      rdy_q     <= 1'b0;
      m_q       <= RST_BUNDLE;
      s_q       <= RST_BUNDLE;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      rdy_q     <= !s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_pc    = m_q.pc;
  assign rs1       = m_q.rs1;
  assign rs2       = m_q.rs2;
  assign rd        = m_q.rd;
  assign imm       = m_q.imm;
  assign r_we      = m_q.r_we;
  assign rv_op     = m_q.op;
  assign illegal   = m_q.illegal;

endmodule
